// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Holds the FSM state encoding, the default reset and trap vectors, the
// sequential PC step, and a few small PC helper functions.
package fetch_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_TRAP    = 3'd4
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam logic [31:0] PC_INCR              = 32'd4;

    // Sequential next PC; the 32-bit add wraps 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] pc_increment(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

    // Clear the byte-offset bits so the target is word aligned.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return target & ~32'h0000_0003;
    endfunction

    // A target is misaligned when either byte-offset bit is set.
    function automatic logic is_misaligned(input logic [31:0] target);
        return (target[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Bus bundle between the fetch sequencer, instruction memory and the core.
//
// Handshakes: a transfer happens on a rising clk edge where both the valid
// and its matching ready are 1. Once valid is raised, valid and its payload
// stay stable until that transfer. Pairs:
//   imem_req_valid / imem_req_ready  (payload imem_req_addr)
//   if_valid       / if_ready        (payload if_instr, if_pc)
//   trap_valid     / trap_ack        (payload trap_addr)
// imem_rsp_valid has no ready; it is taken only while a fetch is outstanding.
interface fetch_seq_ctrl_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        trap_valid;
    logic [31:0] trap_addr;
    logic        trap_ack;
    logic [31:0] fetch_count;

    // Fetch sequencer side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_instr, if_pc,
        input  if_ready, redirect_valid, redirect_pc, stall,
        output trap_valid, trap_addr,
        input  trap_ack,
        output fetch_count
    );

    // Memory / core / environment side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_instr, if_pc,
        output if_ready, redirect_valid, redirect_pc, stall,
        input  trap_valid, trap_addr,
        output trap_ack,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: issues one memory request at a time from the
// PC, holds the returned word for the core, then advances the PC either
// sequentially or to the redirect target taken on the delivery handshake.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, a misaligned
// next-PC target raises a trap instead of being silently word-aligned.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic             clk,
    input  logic             rst,
    fetch_seq_ctrl_if.master bus,
    output fetch_state_t     state_dbg
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  fetch_count_q;
    logic [31:0]  if_instr_q;
    logic [31:0]  if_pc_q;
    logic         req_valid_q;
    logic         if_valid_q;

    logic [31:0]  raw_target;
    logic [31:0]  next_pc;
    logic         misaligned;
    logic         deliver_fire;

    // Next-PC selection; redirect only matters on the delivery handshake.
    always_comb begin
        raw_target   = bus.redirect_valid ? bus.redirect_pc : pc_increment(pc);
        deliver_fire = (state == ST_DELIVER) && bus.if_ready;
`ifdef MISALIGN_TRAP_EN
        next_pc      = raw_target;
        misaligned   = is_misaligned(raw_target);
`else
        next_pc      = align_target(raw_target);
        misaligned   = 1'b0;
`endif
    end

    // Main sequencer FSM with registered valids, PC and delivered-word hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pc            <= RESET_VECTOR;
            fetch_count_q <= 32'd0;
            if_instr_q    <= 32'd0;
            if_pc_q       <= 32'd0;
            req_valid_q   <= 1'b0;
            if_valid_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus.stall) begin
                        state       <= ST_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // stall is not looked at here: a presented request completes.
                    if (bus.imem_req_ready) begin
                        state       <= ST_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if_instr_q <= bus.imem_rsp_data;
                        if_pc_q    <= pc;
                        if_valid_q <= 1'b1;
                        state      <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (deliver_fire) begin
                        if_valid_q    <= 1'b0;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        if (misaligned) begin
                            state <= ST_TRAP;
                        end else begin
                            pc <= next_pc;
                            if (bus.stall) begin
                                state <= ST_IDLE;
                            end else begin
                                state       <= ST_REQ;
                                req_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_TRAP: begin
                    if (bus.trap_ack) begin
                        pc          <= TRAP_VECTOR;
                        state       <= ST_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_valid_q <= 1'b0;
                    if_valid_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic        trap_valid_q;
    logic [31:0] trap_addr_q;

    // Capture the offending target on a misaligned handshake; clear on ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_valid_q <= 1'b0;
            trap_addr_q  <= 32'd0;
        end else if (deliver_fire && misaligned) begin
            trap_valid_q <= 1'b1;
            trap_addr_q  <= raw_target;
        end else if ((state == ST_TRAP) && bus.trap_ack) begin
            trap_valid_q <= 1'b0;
        end
    end

    assign bus.trap_valid = trap_valid_q;
    assign bus.trap_addr  = trap_addr_q;
`else
    assign bus.trap_valid = 1'b0;
    assign bus.trap_addr  = 32'd0;
`endif

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.fetch_count    = fetch_count_q;
    assign state_dbg          = state;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed vector table, hand-written corner
// sequences (address wrap, misaligned target, reset mid-fetch), then a
// randomized run against a transaction-level reference model.
module tb_fetch_seq_ctrl;
    import fetch_seq_ctrl_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic         clk = 1'b0;
    logic         rst;
    fetch_state_t state_dbg;

    fetch_seq_ctrl_if bus();

    fetch_seq_ctrl #(
        .RESET_VECTOR(RV),
        .TRAP_VECTOR (TV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic rdy, input logic rv,
                         input logic [31:0] data, input logic ifr,
                         input logic redv, input logic [31:0] redpc);
        bus.stall          = s;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = data;
        bus.if_ready       = ifr;
        bus.redirect_valid = redv;
        bus.redirect_pc    = redpc;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        bus.trap_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        s, rdy, rv;
        logic [31:0] data;
        logic        ifr, redv;
        logic [31:0] redpc;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic        e_if_v;
        logic [31:0] e_if_pc, e_instr, e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic rdy, input logic rv,
                                input logic [31:0] data, input logic ifr,
                                input logic redv, input logic [31:0] redpc,
                                input logic e_req_v, input logic [31:0] e_addr,
                                input logic e_if_v, input logic [31:0] e_if_pc,
                                input logic [31:0] e_instr, input logic [31:0] e_cnt);
        vec_t v;
        v.s = s; v.rdy = rdy; v.rv = rv; v.data = data; v.ifr = ifr;
        v.redv = redv; v.redpc = redpc; v.e_req_v = e_req_v; v.e_addr = e_addr;
        v.e_if_v = e_if_v; v.e_if_pc = e_if_pc; v.e_instr = e_instr; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t vecs[23];

    // ---------------- reference model state ----------------
    logic [31:0] exp_q[$];   // expected request addresses, in order
    logic [63:0] del_q[$];   // {pc, instr} words awaiting delivery
    logic        req_active, outstanding, prev_stall;
    logic [31:0] cur_addr, model_cnt;
    int          delivered;

    initial begin
        //   s  rdy rv data           ifr rdv redpc        | req addr          ifv if_pc        instr          cnt
        vecs[0]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 32'h0,        0, 32'h0,  32'h0,         32'd0);
        vecs[1]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h0,        0, 32'h0,  32'h0,         32'd0);
        vecs[2]  = mk(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0,  32'h0,         32'd0);
        vecs[3]  = mk(0, 0, 1, 32'h13,        0, 0, 32'h0,  0, 32'h0,        1, 32'h0,  32'h13,        32'd0);
        vecs[4]  = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,  1, 32'h4,        0, 32'h0,  32'h0,         32'd1);
        vecs[5]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,  0, 32'h4,        0, 32'h0,  32'h0,         32'd1);
        vecs[6]  = mk(0, 0, 1, 32'h13,        0, 0, 32'h0,  0, 32'h4,        1, 32'h4,  32'h13,        32'd1);
        vecs[7]  = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,  1, 32'h8,        0, 32'h0,  32'h0,         32'd2);
        for (int i = 8; i < 13; i++)
            vecs[i] = mk(1, 0, 1, 32'hBAD,    0, 1, 32'h80, 1, 32'h8,        0, 32'h0,  32'h0,         32'd2);
        vecs[13] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,  0, 32'h8,        0, 32'h0,  32'h0,         32'd2);
        vecs[14] = mk(0, 0, 0, 32'h0,         0, 1, 32'h80, 0, 32'h8,        0, 32'h0,  32'h0,         32'd2);
        vecs[15] = mk(0, 0, 1, 32'h67,        0, 0, 32'h0,  0, 32'h8,        1, 32'h8,  32'h67,        32'd2);
        vecs[16] = mk(0, 0, 0, 32'h0,         0, 1, 32'h80, 0, 32'h8,        1, 32'h8,  32'h67,        32'd2);
        vecs[17] = mk(0, 0, 0, 32'h0,         1, 1, 32'h40, 1, 32'h40,       0, 32'h0,  32'h0,         32'd3);
        vecs[18] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,  0, 32'h40,       0, 32'h0,  32'h0,         32'd3);
        vecs[19] = mk(0, 0, 1, 32'h11,        0, 0, 32'h0,  0, 32'h40,       1, 32'h40, 32'h11,        32'd3);
        vecs[20] = mk(1, 0, 0, 32'h0,         1, 0, 32'h0,  0, 32'h44,       0, 32'h0,  32'h0,         32'd4);
        vecs[21] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 32'h44,       0, 32'h0,  32'h0,         32'd4);
        vecs[22] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h44,       0, 32'h0,  32'h0,         32'd4);

        // ---- reset state ----
        apply_reset();
        check1 ("rst_req_valid",  bus.imem_req_valid, 1'b0);
        check32("rst_req_addr",   bus.imem_req_addr,  RV);
        check1 ("rst_if_valid",   bus.if_valid,       1'b0);
        check32("rst_if_pc",      bus.if_pc,          32'd0);
        check32("rst_if_instr",   bus.if_instr,       32'd0);
        check32("rst_count",      bus.fetch_count,    32'd0);
        check1 ("rst_trap_valid", bus.trap_valid,     1'b0);
        check32("rst_trap_addr",  bus.trap_addr,      32'd0);
        check32("rst_state",      32'(state_dbg),     32'(ST_IDLE));

        // ---- directed table ----
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].s, vecs[i].rdy, vecs[i].rv, vecs[i].data, vecs[i].ifr,
                  vecs[i].redv, vecs[i].redpc);
            step();
            check1 ($sformatf("vec%0d_req_valid", i), bus.imem_req_valid, vecs[i].e_req_v);
            check32($sformatf("vec%0d_req_addr", i),  bus.imem_req_addr,  vecs[i].e_addr);
            check1 ($sformatf("vec%0d_if_valid", i),  bus.if_valid,       vecs[i].e_if_v);
            check32($sformatf("vec%0d_count", i),     bus.fetch_count,    vecs[i].e_cnt);
            if (vecs[i].e_if_v) begin
                check32($sformatf("vec%0d_if_pc", i),    bus.if_pc,    vecs[i].e_if_pc);
                check32($sformatf("vec%0d_if_instr", i), bus.if_instr, vecs[i].e_instr);
            end
        end

        // ---- PC wrap: redirect to 0xFFFF_FFFC, then sequential ----
        drive(0, 1, 0, 32'h0,  0, 0, 32'h0); step();
        drive(0, 0, 1, 32'h13, 0, 0, 32'h0); step();
        drive(0, 0, 0, 32'h0,  1, 1, 32'hFFFF_FFFC); step();
        check1 ("wrap_req_valid_hi", bus.imem_req_valid, 1'b1);
        check32("wrap_req_addr_hi",  bus.imem_req_addr,  32'hFFFF_FFFC);
        drive(0, 1, 0, 32'h0,  0, 0, 32'h0); step();
        drive(0, 0, 1, 32'h13, 0, 0, 32'h0); step();
        check32("wrap_if_pc",        bus.if_pc,          32'hFFFF_FFFC);
        drive(0, 0, 0, 32'h0,  1, 0, 32'h0); step();
        check1 ("wrap_req_valid_0",  bus.imem_req_valid, 1'b1);
        check32("wrap_req_addr_0",   bus.imem_req_addr,  32'h0);
        check32("wrap_count",        bus.fetch_count,    32'd6);

        // ---- misaligned redirect target 0x42 ----
        drive(0, 1, 0, 32'h0,  0, 0, 32'h0); step();
        drive(0, 0, 1, 32'h13, 0, 0, 32'h0); step();
        drive(0, 0, 0, 32'h0,  1, 1, 32'h42); step();
        check32("mis_count", bus.fetch_count, 32'd7);
`ifdef MISALIGN_TRAP_EN
        check1 ("mis_trap_valid", bus.trap_valid,     1'b1);
        check32("mis_trap_addr",  bus.trap_addr,      32'h42);
        check1 ("mis_no_req",     bus.imem_req_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 32'h5, 0, 0, 32'h0); step();
            check1 ("mis_trap_hold",     bus.trap_valid,     1'b1);
            check1 ("mis_no_req_hold",   bus.imem_req_valid, 1'b0);
        end
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        bus.trap_ack = 1'b1; step(); bus.trap_ack = 1'b0;
        check1 ("mis_ack_req_valid", bus.imem_req_valid, 1'b1);
        check32("mis_ack_req_addr",  bus.imem_req_addr,  TV);
        check1 ("mis_ack_trap_clr",  bus.trap_valid,     1'b0);
`else
        check1 ("mis_req_valid",  bus.imem_req_valid, 1'b1);
        check32("mis_req_addr",   bus.imem_req_addr,  32'h40);
        check1 ("mis_trap_valid", bus.trap_valid,     1'b0);
        check32("mis_trap_addr",  bus.trap_addr,      32'h0);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        bus.trap_ack = 1'b1; step(); bus.trap_ack = 1'b0;
        check1 ("mis_ack_ignored_v", bus.imem_req_valid, 1'b1);
        check32("mis_ack_ignored_a", bus.imem_req_addr,  32'h40);
        check1 ("mis_ack_no_trap",   bus.trap_valid,     1'b0);
`endif

        // ---- reset while waiting for a response, then a stray response ----
        drive(0, 1, 0, 32'h0, 0, 0, 32'h0); step();
        check1 ("rw_in_wait_req", bus.imem_req_valid, 1'b0);
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0); step();
        rst = 1'b0;
        drive(1, 0, 1, 32'h77, 0, 0, 32'h0); step();
        check32("rw_count",      bus.fetch_count,    32'd0);
        check1 ("rw_if_valid",   bus.if_valid,       1'b0);
        check1 ("rw_req_idle",   bus.imem_req_valid, 1'b0);
        drive(0, 0, 1, 32'h77, 0, 0, 32'h0); step();
        check1 ("rw_req_valid",  bus.imem_req_valid, 1'b1);
        check32("rw_req_addr",   bus.imem_req_addr,  RV);
        check1 ("rw_if_valid2",  bus.if_valid,       1'b0);
        drive(0, 0, 1, 32'h77, 0, 0, 32'h0); step();
        check1 ("rw_if_valid3",  bus.if_valid,       1'b0);

        // ---- randomized run against the transaction model ----
        exp_q.delete();
        del_q.delete();
        exp_q.push_back(RV);
        req_active = 1'b0;
        outstanding = 1'b0;
        prev_stall = 1'b0;
        cur_addr = 32'd0;
        model_cnt = 32'd0;
        delivered = 0;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        s, rdy, rv, ifr, redv;
            logic [31:0] data, redpc, dpc;
            logic [63:0] front;

            // observe the outputs settled after the last edge
            if (bus.imem_req_valid && !req_active) begin
                check1 ("rnd_req_after_stall", prev_stall, 1'b0);
                check32("rnd_one_in_flight", 32'(del_q.size()) + 32'(outstanding), 32'd0);
                check32("rnd_exp_q_depth", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    check32("rnd_req_addr", bus.imem_req_addr, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                req_active = 1'b1;
                cur_addr = bus.imem_req_addr;
            end else if (bus.imem_req_valid) begin
                check32("rnd_req_addr_stable", bus.imem_req_addr, cur_addr);
            end
            check1("rnd_if_valid", bus.if_valid, del_q.size() != 0);
            if (bus.if_valid && del_q.size() != 0) begin
                front = del_q[0];
                check32("rnd_if_pc",    bus.if_pc,    front[63:32]);
                check32("rnd_if_instr", bus.if_instr, front[31:0]);
            end
            check32("rnd_fetch_count", bus.fetch_count, model_cnt);

            // random stimulus for the next edge
            s     = ($urandom_range(0, 3) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
            rv    = ($urandom_range(0, 1) == 1);
            data  = $urandom;
            ifr   = ($urandom_range(0, 1) == 1);
            redv  = ($urandom_range(0, 3) == 0);
            redpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive(s, rdy, rv, data, ifr, redv, redpc);

            // model: what this coming edge does at transaction level
            if (outstanding && rv) begin
                del_q.push_back({cur_addr, data});
                outstanding = 1'b0;
            end
            if (bus.imem_req_valid && rdy && req_active) begin
                outstanding = 1'b1;
                req_active = 1'b0;
            end
            if (bus.if_valid && ifr && del_q.size() != 0) begin
                front = del_q.pop_front();
                dpc = front[63:32];
                exp_q.push_back(redv ? redpc : dpc + 32'd4);
                model_cnt = model_cnt + 32'd1;
                delivered++;
            end
            prev_stall = s;
            step();
        end
        check1("rnd_progress", delivered >= 100, 1'b1);

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_seq_ctrl.md
FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, SHALL be the PC loaded after a misaligned-target trap is acknowledged.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_addr  out  32  fetch address; equals current PC.
REQ-007 imem_req_ready  in  1  memory accepts request.
REQ-008 imem_rsp_valid  in  1  instruction word returned.
REQ-009 imem_rsp_data  in  32  instruction word.
REQ-010 if_valid  out  1  instruction offered to core.
REQ-011 if_instr  out  32  held instruction.
REQ-012 if_pc  out  32  PC of held instruction.
REQ-013 if_ready  in  1  core consumes instruction this cycle.
REQ-014 redirect_valid  in  1  non-sequential next PC (JAL/JALR/taken branch).
REQ-015 redirect_pc  in  32  next-PC target from next-PC logic.
REQ-016 stall  in  1  hold fetch before the next request is issued.
REQ-017 trap_valid  out  1  misaligned-target trap pending.
REQ-018 trap_addr  out  32  offending target.
REQ-019 trap_ack  in  1  trap handled.
REQ-020 fetch_count  out  32  instructions consumed since reset.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, DELIVER, TRAP.
REQ-022 IDLE: all valids 0; next state REQ when stall=0, else remain in IDLE.
REQ-023 REQ: imem_req_valid=1 with addr=PC, held stable until imem_req_ready=1; then next state WAIT; stall SHALL NOT abort a request already presented.
REQ-024 WAIT: on imem_rsp_valid, capture data into if_instr and PC into if_pc, then next state DELIVER; a response in the same cycle as request acceptance SHALL be ignored.
REQ-025 imem_rsp_valid in any state other than WAIT SHALL be ignored.
REQ-026 DELIVER: if_valid=1, with if_instr and if_pc stable until if_ready=1.
REQ-027 On the DELIVER handshake: PC <= redirect_valid ? redirect_pc : PC+4; fetch_count increments by 1; next state is TRAP per REQ-033, else IDLE if stall=1, else REQ.
REQ-028 redirect_valid SHALL be sampled only on the DELIVER handshake cycle and ignored otherwise.
REQ-029 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); fetch_count SHALL also wrap.
REQ-030 With a zero-wait memory, throughput SHALL be one instruction per 3 cycles (REQ, WAIT, DELIVER with if_ready=1).
REQ-031 imem_req_addr and if_pc SHALL be registered outputs, not combinational on inputs.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, PC=RESET_VECTOR, fetch_count=0, if_instr=0, if_pc=0, trap_addr=0, and all valid outputs=0. Reset mid-WAIT discards the outstanding fetch; memory is reset by the same rst, so no response returns.

Configuration
REQ-033 With MISALIGN_TRAP_EN defined, a handshake target with bits[1:0]!=0 SHALL enter TRAP: trap_valid=1 and trap_addr=target, with no fetch issued. On trap_ack: PC=TRAP_VECTOR, next state REQ.
REQ-034 Without MISALIGN_TRAP_EN: TRAP is unreachable, trap_valid and trap_addr are tied to 0, the target has bits[1:0] forced to 0, and trap_ack is ignored.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the RESET_VECTOR/TRAP_VECTOR defaults and the PC increment constant 4.
REQ-036 The FSM, PC and counter SHALL live in one module, with no sub-module required.

Verification
REQ-037 Reset, then zero-wait memory returning 32'h0000_0013: request at addr 0, if_valid with if_pc=0; with if_ready=1, next request at addr 4, three cycles per instruction.
REQ-038 imem_req_ready held low 5 cycles in REQ: imem_req_valid=1 and imem_req_addr unchanged throughout.
REQ-039 Handshake with redirect_valid=1 and redirect_pc=32'h0000_0040: next request at addr 32'h40; redirect_valid asserted outside DELIVER has no effect.
REQ-040 PC=32'hFFFF_FFFC, handshake without redirect: next request at 32'h0000_0000.
REQ-041 With MISALIGN_TRAP_EN, redirect_pc=32'h0000_0042: trap_valid=1 with trap_addr=32'h42, no request issued; trap_ack leads to a request at 32'h100. Without the macro, the same stimulus gives a request at 32'h40.
REQ-042 rst asserted in WAIT with a later stray imem_rsp_valid: fetch_count=0, if_valid stays 0, and the first request is at RESET_VECTOR.
